// File: rtl/instr_sequencer_if.sv
// Memory handshake bundle between the sequencer (master) and the
// instruction/data memories (slave).
interface instr_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic MemR;
  logic MemW;

  modport master (
    output imem_req, dmem_req, MemR, MemW,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, MemR, MemW,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-opcode datapath,
// with req/ack memory handshakes, ack timeout and a retired-instruction counter.
module instr_sequencer #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic [2:0]           Opcode,
  input  logic                 NotEq,
  input  logic                 Last_instr,
  instr_sequencer_if.master    mem,
  output logic                 IR_load,
  output logic [1:0]           ALUOp,
  output logic                 RegW,
  output logic                 PC_en,
  output logic                 PC_sel,
  output logic                 Done,
  output logic                 Err,
  output logic [CNT_W-1:0]     Retired
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_SB, OP_LB, OP_ADD, OP_AND, OP_XOR, OP_CPY, OP_SL, OP_BNE
  } op_t;

  state_t              r_state;
  op_t                 r_op_q;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_retired;
  logic                r_err;

  logic                w_ack;
  logic                w_timeout;
  logic                w_retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Only the ack belonging to the current wait state is seen; others are ignored.
  always_comb begin
    w_ack     = 1'b0;
    if (r_state == S_FETCH)
      w_ack = mem.imem_ack;
    else if (r_state == S_MEM)
      w_ack = mem.dmem_ack;
    w_timeout = !w_ack && (r_wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));
    w_retire  = ((r_state == S_EXEC) && (r_op_q == OP_BNE)) ||
                ((r_state == S_MEM) && w_ack && (r_op_q == OP_SB)) ||
                (r_state == S_WB);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_op_q     <= OP_SB;
      r_wait_cnt <= '0;
      r_retired  <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (Start) r_state <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (w_ack) begin
            r_wait_cnt <= '0;
            if (r_state == S_FETCH)
              r_state <= S_DECODE;
            else if (r_op_q == OP_LB)
              r_state <= S_WB;
          end else if (w_timeout) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b1;
            r_state    <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          r_op_q  <= op_t'(Opcode);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (r_op_q == OP_SB || r_op_q == OP_LB)
            r_state <= S_MEM;
          else if (r_op_q != OP_BNE)
            r_state <= S_WB;
        end
        S_HALT: begin
          if (Start) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_err     <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Every retiring state (bne EXEC, sb MEM ack, WB) funnels through here.
      if (w_retire) begin
        r_retired <= sat_inc(r_retired);
        r_state   <= Last_instr ? S_HALT : S_FETCH;
      end
    end
  end

  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.MemR     = 1'b0;
    mem.MemW     = 1'b0;
    IR_load      = 1'b0;
    ALUOp        = 2'd0;
    RegW         = 1'b0;
    PC_en        = 1'b0;
    PC_sel       = 1'b0;
    Done         = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        IR_load      = mem.imem_ack;
      end
      S_EXEC: begin
        case (r_op_q)
          OP_ADD: ALUOp = 2'd1;
          OP_XOR: ALUOp = 2'd2;
          OP_BNE: begin
            ALUOp  = 2'd3;
            PC_en  = 1'b1;
            PC_sel = NotEq;
          end
          default: ALUOp = 2'd0;
        endcase
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.MemW     = (r_op_q == OP_SB);
        mem.MemR     = (r_op_q == OP_LB);
        PC_en        = mem.dmem_ack && (r_op_q == OP_SB);
      end
      S_WB: begin
        RegW  = 1'b1;
        PC_en = 1'b1;
      end
      S_HALT: Done = 1'b1;
      default: Done = 1'b0;
    endcase
  end

  assign Err     = r_err;
  assign Retired = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench: an instruction-level timeline model expands each program
// into per-cycle stimulus and expected outputs, then replays it against the DUT.
module tb_instr_sequencer;

  localparam int ACK_TO = 15;
  localparam int CW     = 3;

  localparam logic [2:0] OP_SB = 3'd0, OP_LB = 3'd1, OP_ADD = 3'd2, OP_XOR = 3'd4, OP_BNE = 3'd7;

  localparam logic [11:0] IREQ = 12'h800, DREQ = 12'h400, MEMR = 12'h200, MEMW = 12'h100,
                          IRL  = 12'h080, ALU1 = 12'h020, ALU2 = 12'h040, ALU3 = 12'h060,
                          REGW = 12'h010, PCEN = 12'h008, PCSL = 12'h004, DONE = 12'h002,
                          ERRB = 12'h001;

  typedef struct packed {
    logic       rst_n;
    logic       start;
    logic [2:0] opc;
    logic       ne;
    logic       last;
    logic       iack;
    logic       dack;
  } stim_t;

  typedef struct packed {
    logic          chk;
    logic [11:0]   outs;
    logic [CW-1:0] ret;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, start, ne, last;
  logic [2:0]    opc;
  logic          IR_load, RegW, PC_en, PC_sel, Done, Err;
  logic [1:0]    ALUOp;
  logic [CW-1:0] Retired;
  logic [11:0]   obs;

  instr_sequencer_if mif();

  instr_sequencer #(.ACK_TIMEOUT(ACK_TO), .CNT_W(CW)) dut (
    .CLK(clk), .Reset_n(rst_n), .Start(start), .Opcode(opc), .NotEq(ne),
    .Last_instr(last), .mem(mif), .IR_load(IR_load), .ALUOp(ALUOp), .RegW(RegW),
    .PC_en(PC_en), .PC_sel(PC_sel), .Done(Done), .Err(Err), .Retired(Retired)
  );

  always #5 clk = ~clk;

  assign obs = {mif.imem_req, mif.dmem_req, mif.MemR, mif.MemW, IR_load, ALUOp,
                RegW, PC_en, PC_sel, Done, Err};

  stim_t sq[$];
  exp_t  eq[$];
  int    m_ret;
  logic  m_err;
  logic  m_last;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cur_cyc  = 0;

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cur_cyc, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic int rdelay();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10) return 0;
    if (r < 15) return r - 9;
    if (r < 18) return ACK_TO - 1;
    return ACK_TO;
  endfunction

  task automatic emit(input logic rs, input logic st, input logic ia, input logic da,
                      input logic [2:0] op, input logic n, input logic [11:0] outs,
                      input logic chk);
    stim_t s;
    exp_t  e;
    s = '{rst_n: rs, start: st, opc: op, ne: n, last: m_last, iack: ia, dack: da};
    e = '{chk: chk, outs: outs, ret: CW'(m_ret)};
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic retire(output bit stop);
    m_ret = (m_ret >= (1 << CW) - 1) ? (1 << CW) - 1 : m_ret + 1;
    stop  = m_last;
  endtask

  // A req waits 'delay' empty cycles, then sees its ack; delay >= ACK_TO never acks.
  task automatic wait_phase(input bit is_fetch, input int delay, input logic [11:0] base,
                            input logic [11:0] on_ack, output bit timed_out);
    int n;
    n = (delay >= ACK_TO) ? ACK_TO : delay;
    for (int k = 0; k < n; k++)
      emit(1, rb(), is_fetch ? 1'b0 : rb(), is_fetch ? rb() : 1'b0, rop(), rb(), base, 1);
    if (delay >= ACK_TO) begin
      timed_out = 1;
      m_err     = 1;
    end else begin
      timed_out = 0;
      emit(1, rb(), is_fetch ? 1'b1 : rb(), is_fetch ? rb() : 1'b1, rop(), rb(), base | on_ack, 1);
    end
  endtask

  task automatic run_instr(input logic [2:0] op, input logic n, input int fd, input int dd,
                           input logic is_last, output bit stop);
    bit          to;
    logic [11:0] alu;
    stop   = 0;
    m_last = is_last;
    wait_phase(1, fd, IREQ, IRL, to);
    if (to) begin
      stop = 1;
      return;
    end
    emit(1, rb(), rb(), rb(), op, rb(), 12'h000, 1);
    alu = (op == OP_ADD) ? ALU1 : (op == OP_XOR) ? ALU2 : (op == OP_BNE) ? ALU3 : 12'h000;
    if (op == OP_BNE) begin
      emit(1, rb(), rb(), rb(), rop(), n, alu | PCEN | (n ? PCSL : 12'h000), 1);
      retire(stop);
      return;
    end
    emit(1, rb(), rb(), rb(), rop(), rb(), alu, 1);
    if (op == OP_SB || op == OP_LB) begin
      wait_phase(0, dd, DREQ | ((op == OP_SB) ? MEMW : MEMR), (op == OP_SB) ? PCEN : 12'h000, to);
      if (to) begin
        stop = 1;
        return;
      end
      if (op == OP_SB) begin
        retire(stop);
        return;
      end
    end
    emit(1, rb(), rb(), rb(), rop(), rb(), REGW | PCEN, 1);
    retire(stop);
  endtask

  task automatic halt_cycles(input int n);
    for (int k = 0; k < n; k++)
      emit(1, 0, rb(), rb(), rop(), rb(), DONE | (m_err ? ERRB : 12'h000), 1);
  endtask

  task automatic restart();
    emit(1, 1, rb(), rb(), rop(), rb(), DONE | (m_err ? ERRB : 12'h000), 1);
    m_ret = 0;
    m_err = 0;
  endtask

  task automatic run_prog(input int n, input bit long_delays);
    bit stop;
    stop = 0;
    for (int i = 0; i < n && !stop; i++) begin
      if (long_delays)
        run_instr(rop(), rb(), rdelay(), rdelay(), i == n - 1, stop);
      else
        run_instr(rop(), rb(), $urandom_range(0, 2), $urandom_range(0, 2), i == n - 1, stop);
    end
    halt_cycles(2);
  endtask

  task automatic build();
    bit stop;
    m_ret  = 0;
    m_err  = 0;
    m_last = 0;
    // reset with Start and both acks high; outputs before the first edge are unknown
    emit(0, 1, 1, 1, rop(), rb(), 12'h000, 0);
    emit(0, 1, 1, 1, rop(), rb(), 12'h000, 1);
    emit(1, 1, rb(), rb(), rop(), rb(), 12'h000, 1);
    run_instr(OP_ADD, 0, 0, 0, 0, stop);
    run_instr(OP_XOR, 0, 0, 0, 1, stop);
    halt_cycles(3);
    restart();
    run_instr(OP_BNE, 1, 0, 0, 0, stop);
    run_instr(OP_BNE, 0, 0, 0, 1, stop);
    halt_cycles(2);
    restart();
    run_instr(OP_LB, 0, 0, 3, 0, stop);
    run_instr(OP_SB, 0, 1, 2, 1, stop);
    halt_cycles(2);
    restart();
    run_instr(OP_ADD, 0, ACK_TO, 0, 1, stop);
    halt_cycles(3);
    restart();
    run_instr(OP_ADD, 0, ACK_TO - 1, 0, 1, stop);
    halt_cycles(2);
    restart();
    run_instr(OP_LB, 0, 0, ACK_TO, 1, stop);
    halt_cycles(2);
    restart();
    run_prog(10, 0);
    for (int p = 0; p < 8; p++) begin
      restart();
      run_prog($urandom_range(1, 8), 1);
    end
    // reset lands while an lb is waiting in MEM
    restart();
    run_instr(OP_ADD, 0, 0, 0, 0, stop);
    m_last = 0;
    emit(1, rb(), 1, rb(), rop(), rb(), IREQ | IRL, 1);
    emit(1, rb(), rb(), rb(), OP_LB, rb(), 12'h000, 1);
    emit(1, rb(), rb(), rb(), rop(), rb(), 12'h000, 1);
    emit(1, rb(), rb(), 0, rop(), rb(), DREQ | MEMR, 1);
    emit(0, 1, 1, 1, rop(), rb(), DREQ | MEMR, 1);
    m_ret = 0;
    m_err = 0;
    emit(1, 0, rb(), rb(), rop(), rb(), 12'h000, 1);
    emit(1, 0, rb(), rb(), rop(), rb(), 12'h000, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b1;
    opc          = 3'd0;
    ne           = 1'b0;
    last         = 1'b0;
    mif.imem_ack = 1'b1;
    mif.dmem_ack = 1'b1;
    build();
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      rst_n        = sq[i].rst_n;
      start        = sq[i].start;
      opc          = sq[i].opc;
      ne           = sq[i].ne;
      last         = sq[i].last;
      mif.imem_ack = sq[i].iack;
      mif.dmem_ack = sq[i].dack;
      #1;
      cur_cyc = i;
      if (eq[i].chk) begin
        chk_eq("outputs", 16'(obs), 16'(eq[i].outs));
        chk_eq("retired", 16'(Retired), 16'(eq[i].ret));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer that drives the 8-opcode datapath (sb, lb, add, and, xor, cpy, sl, bne).
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memory using req/ack, with an ack timeout.
- Generates per-state control strobes, advances the PC, counts retired instructions and reports Done/Err to the top level.

Parameters:
- ACK_TIMEOUT, 15: max cycles a memory req waits for ack (≥2).
- CNT_W, 16: width of retired-instruction counter.

Ports:
- CLK  in  1  clock
- Reset_n  in  1  synchronous active-low reset
- Start  in  1  begin/restart program execution
- Opcode  in  3  IR[8:6], valid from cycle after IR_load
- NotEq  in  1  ALU compare result, valid in EXEC
- Last_instr  in  1  PC points at final instruction
- imem_ack  in  1  instruction word valid
- dmem_ack  in  1  data access complete
- imem_req  out  1  fetch request
- dmem_req  out  1  data request
- MemR  out  1  data read (lb)
- MemW  out  1  data write (sb)
- IR_load  out  1  latch instruction register
- ALUOp  out  2  0 pass/and, 1 add, 2 xor, 3 compare
- RegW  out  1  register-file write
- PC_en  out  1  PC update strobe
- PC_sel  out  1  1 = branch target, 0 = PC+1
- Done  out  1  program halted
- Err  out  1  memory ack timeout occurred
- Retired  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore, decoded from state and latched opcode op_q, except IR_load, PC_en and PC_sel, which are also gated by ack/NotEq in the same cycle.
- Reset (Reset_n=0 at CLK edge): state=IDLE, op_q=0, wait_cnt=0, Retired=0, Err=0. All outputs 0. Reset mid-operation aborts immediately; req drops the cycle after the edge. Reset beats all other inputs.
- IDLE: outputs 0; Start=1 → FETCH.
- FETCH: imem_req=1.
  - imem_ack=1 → IR_load=1 this cycle, → DECODE.
  - Otherwise stay.
- DECODE: one cycle; op_q←Opcode; → EXEC.
- EXEC: ALUOp per op_q.
  - ALUOp codes: add=1, xor=2, bne=3, others 0.
  - bne: PC_en=1, PC_sel=NotEq; retire.
  - sb/lb → MEM.
  - Others → WB.
- MEM: dmem_req=1; MemW=1 (sb) or MemR=1 (lb), held until ack.
  - dmem_ack with sb → PC_en=1, retire.
  - dmem_ack with lb → WB.
- WB: RegW=1, PC_en=1, PC_sel=0; retire.
- Retire: Retired increments by 1 and saturates at all-ones. Next state is HALT if Last_instr=1, else FETCH.
- HALT: Done=1, everything else 0. Start=1 → FETCH, with Retired←0 and Err←0 on that edge.
- Latency, zero-wait memory:
  - ALU op: 4 cycles.
  - bne: 3 cycles.
  - sb: 4 cycles.
  - lb: 5 cycles.
- Timeout:
  - wait_cnt increments each FETCH/MEM cycle with no ack and clears on ack or state exit.
  - No ack with wait_cnt==ACK_TIMEOUT-1 → HALT, Err=1 (sticky until restart); the instruction does not retire.
  - Ack is accepted in waiting cycles 1..ACK_TIMEOUT; ack on the final cycle wins over timeout.
- Acks arriving outside their own wait state are ignored.
- Start is ignored outside IDLE/HALT.
- PC_en is high for exactly one cycle per retired instruction.
- RegW is never high for sb or bne.
- MemW/MemR are never high outside MEM.

Test Plan:
- Reset_n=0 for 2 cycles, with Start=1 and both acks=1 → all outputs 0, state IDLE. Releasing reset with Start=1 → imem_req=1 next cycle.
- Program add, xor, Last_instr on xor, acks tied 1 → the following are observed:
  - ALUOp=1 in cycle 3.
  - ALUOp=2 in cycle 7.
  - RegW/PC_en in cycles 4 and 8.
  - Done=1 from cycle 9; Retired=2.
- bne with NotEq=1, then bne with NotEq=0 → PC_en=1 in EXEC both times; PC_sel=1 then 0; RegW stays 0.
- lb with dmem_ack delayed 3 cycles → MemR/dmem_req held 4 cycles, then RegW=1 for exactly one cycle. sb: MemW held until ack, no RegW.
- imem_ack never asserted, ACK_TIMEOUT=15 → after 15 FETCH cycles, HALT with Done=1, Err=1, Retired unchanged. A second run with ack exactly on cycle 15 proceeds to DECODE with Err=0.
- Reset_n=0 asserted during MEM with dmem_req high → dmem_req=0 and MemR=0 the next cycle, state IDLE, Retired=0.
